// File: rtl/snake_step_sequencer.sv
// snake_step_sequencer
// Per-move sequencer for the snake body FIFO. A move strobe latches the new
// head, one full rotation of the body FIFO checks for self-collision, then
// the move is committed (push head, pop tail unless food was eaten).
//
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   tick              one-cycle move strobe, head/food valid with it
//   headX/headY       new head position
//   foodX/foodY       current food position
//   fifo_q            show-ahead body FIFO output {x,y}
//   fifo_wrreq/rdreq  FIFO push/pop requests
//   fifo_data         FIFO write data {x,y}
//   busy              high whenever not IDLE
//   grow              one-cycle pulse in the commit cycle when food is eaten
//   game_over         sticky collision flag (held until reset)
//   length            current body length
//   score             food eaten, saturating at 255
module snake_step_sequencer #(
  parameter int DEPTH = 64,
  parameter int LW    = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic [3:0]    headX,
  input  logic [3:0]    headY,
  input  logic [3:0]    foodX,
  input  logic [3:0]    foodY,
  input  logic [7:0]    fifo_q,
  output logic          fifo_wrreq,
  output logic          fifo_rdreq,
  output logic [7:0]    fifo_data,
  output logic          busy,
  output logic          grow,
  output logic          game_over,
  output logic [LW-1:0] length,
  output logic [7:0]    score
);

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT, OVER} state_t;

  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  state_t        state, state_nxt;
  logic [7:0]    hd;
  logic          eat;
  logic          hit;
  logic [LW-1:0] idx;
  logic          match;
  logic          full;
  logic          tail_free;

  assign full = (length == DEPTH_L);
  // The tail slot is vacated by this move unless the snake grows into it.
  assign tail_free = !eat || full;

  always_comb begin
    state_nxt  = state;
    fifo_wrreq = 1'b0;
    fifo_rdreq = 1'b0;
    fifo_data  = 8'h00;
    grow       = 1'b0;
    match      = 1'b0;
    unique case (state)
      IDLE: begin
        if (tick) state_nxt = (length != '0) ? SCAN : COMMIT;
      end
      SCAN: begin
        // Pop and re-push the front entry: one full pass restores order.
        fifo_rdreq = 1'b1;
        fifo_wrreq = 1'b1;
        fifo_data  = fifo_q;
        match      = (fifo_q == hd) && !((idx == '0) && tail_free);
        if (idx == length - LW'(1)) state_nxt = COMMIT;
      end
      COMMIT: begin
        if (hit) begin
          state_nxt = OVER;
        end else begin
          fifo_wrreq = 1'b1;
          fifo_data  = hd;
          fifo_rdreq = (length != '0) && tail_free;
          grow       = eat;
          state_nxt  = IDLE;
        end
      end
      OVER: state_nxt = OVER;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign game_over = (state == OVER);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      hd     <= 8'h00;
      eat    <= 1'b0;
      hit    <= 1'b0;
      idx    <= '0;
      length <= '0;
      score  <= 8'h00;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (tick) begin
            // Only the eat decision is needed from the food position, so it
            // is resolved here and the inputs may change freely afterwards.
            hd  <= {headX, headY};
            eat <= ({headX, headY} == {foodX, foodY});
            hit <= 1'b0;
            idx <= '0;
          end
        end
        SCAN: begin
          hit <= hit | match;
          idx <= idx + LW'(1);
        end
        COMMIT: begin
          if (!hit) begin
            if ((eat && !full) || (length == '0)) length <= length + LW'(1);
            if (eat && (score != 8'hFF)) score <= score + 8'h01;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_step_sequencer.sv
// Directed bench for snake_step_sequencer with a small show-ahead FIFO
// model (DEPTH=4) so full-length behaviour is reachable quickly.
module tb_snake_step_sequencer;

  localparam int DEPTH = 4;
  localparam int LW    = 3;
  localparam int KMAX  = 24;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          tick = 1'b0;
  logic [3:0]    headX = 4'h0, headY = 4'h0, foodX = 4'h0, foodY = 4'h0;
  logic [7:0]    fifo_q;
  logic          fifo_wrreq, fifo_rdreq;
  logic [7:0]    fifo_data;
  logic          busy, grow, game_over;
  logic [LW-1:0] length;
  logic [7:0]    score;

  int checks = 0;
  int failures = 0;

  snake_step_sequencer #(.DEPTH(DEPTH), .LW(LW)) dut (
    .clk(clk), .reset(reset), .tick(tick),
    .headX(headX), .headY(headY), .foodX(foodX), .foodY(foodY),
    .fifo_q(fifo_q), .fifo_wrreq(fifo_wrreq), .fifo_rdreq(fifo_rdreq),
    .fifo_data(fifo_data), .busy(busy), .grow(grow), .game_over(game_over),
    .length(length), .score(score)
  );

  always #5 clk = ~clk;

  // Show-ahead FIFO model, cleared by the same reset.
  logic [7:0] q[$];
  logic       ovf = 1'b0, udf = 1'b0;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      fifo_q <= 8'h00;
    end else begin
      if (fifo_rdreq) begin
        if (q.size() == 0) udf <= 1'b1;
        else void'(q.pop_front());
      end
      if (fifo_wrreq) q.push_back(fifo_data);
      if (q.size() > DEPTH) ovf <= 1'b1;
      fifo_q <= (q.size() != 0) ? q[0] : 8'h00;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Per-cycle record of one move; index k = cycles after the tick cycle.
  logic       wr_a [1:KMAX];
  logic       rd_a [1:KMAX];
  logic [7:0] dat_a[1:KMAX];
  logic       gr_a [1:KMAX];
  logic       bz_a [1:KMAX];
  logic       go_a [1:KMAX];
  int         busy_cnt, req_cnt, grow_cnt;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    tick  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic move(input logic [7:0] h, input logic [7:0] f, input bit extra);
    busy_cnt = 0; req_cnt = 0; grow_cnt = 0;
    for (int k = 1; k <= KMAX; k++) begin
      wr_a[k] = 0; rd_a[k] = 0; dat_a[k] = 0; gr_a[k] = 0; bz_a[k] = 0; go_a[k] = 0;
    end
    @(negedge clk);
    {headX, headY} = h; {foodX, foodY} = f; tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    // Scramble inputs after the tick; the move must use the latched values.
    {headX, headY} = 8'hEE; {foodX, foodY} = 8'hEE;
    for (int k = 1; k <= KMAX; k++) begin
      wr_a[k] = fifo_wrreq; rd_a[k] = fifo_rdreq; dat_a[k] = fifo_data;
      gr_a[k] = grow; bz_a[k] = busy; go_a[k] = game_over;
      busy_cnt += int'(busy);
      req_cnt  += int'(fifo_wrreq) + int'(fifo_rdreq);
      grow_cnt += int'(grow);
      tick = extra && (k == 1);
      if (!busy) break;
      @(negedge clk);
    end
    tick = 1'b0;
  endtask

  // Body {0x30,0x31,0x32} tail first, length 3, score 2.
  task automatic build3();
    do_reset();
    move(8'h30, 8'h77, 0);
    move(8'h31, 8'h31, 0);
    move(8'h32, 8'h32, 0);
  endtask

  initial begin
    do_reset();
    @(negedge clk);
    chk("rst_length", length, 0);
    chk("rst_score", score, 0);
    chk("rst_busy", busy, 0);
    chk("rst_over", game_over, 0);
    chk("rst_grow", grow, 0);
    chk("rst_wr", fifo_wrreq, 0);
    chk("rst_rd", fifo_rdreq, 0);
    chk("rst_data", fifo_data, 0);

    // First move onto an empty board.
    move(8'h33, 8'h77, 0);
    chk("m0_wr", wr_a[1], 1);
    chk("m0_data", dat_a[1], 8'h33);
    chk("m0_rd", rd_a[1], 0);
    chk("m0_busy_end", bz_a[2], 0);
    chk("m0_grow", grow_cnt, 0);
    chk("m0_length", length, 1);

    // Plain move: rotate 3, push head, pop tail.
    build3();
    chk("b3_length", length, 3);
    chk("b3_score", score, 2);
    move(8'h33, 8'h00, 0);
    for (int k = 1; k <= 3; k++) begin
      chk("mv_rot_wr", wr_a[k], 1);
      chk("mv_rot_rd", rd_a[k], 1);
      chk("mv_rot_data", dat_a[k], 8'h30 + 8'(k - 1));
    end
    chk("mv_c_wr", wr_a[4], 1);
    chk("mv_c_data", dat_a[4], 8'h33);
    chk("mv_c_rd", rd_a[4], 1);
    chk("mv_busy_cnt", busy_cnt, 4);
    chk("mv_length", length, 3);
    chk("mv_tail", q[0], 8'h31);
    chk("mv_head", q[2], 8'h33);

    // Eat: grow, no pop.
    build3();
    move(8'h33, 8'h33, 0);
    chk("eat_grow_t4", gr_a[4], 1);
    chk("eat_grow_cnt", grow_cnt, 1);
    chk("eat_rd", rd_a[4], 0);
    chk("eat_wr", wr_a[4], 1);
    chk("eat_length", length, 4);
    chk("eat_score", score, 3);

    // Collision with body.
    build3();
    move(8'h31, 8'h00, 0);
    chk("hit_wr", wr_a[4], 0);
    chk("hit_rd", rd_a[4], 0);
    chk("hit_over_t4", go_a[4], 0);
    chk("hit_over_t5", go_a[5], 1);
    chk("hit_busy_t5", bz_a[5], 1);
    move(8'h40, 8'h40, 0);
    chk("over_reqs", req_cnt, 0);
    chk("over_flag", game_over, 1);
    chk("over_length", length, 3);

    // Head onto the vacated tail.
    build3();
    move(8'h30, 8'h00, 0);
    chk("tail_over", go_a[5], 0);
    chk("tail_c_data", dat_a[4], 8'h30);
    chk("tail_c_rd", rd_a[4], 1);
    chk("tail_length", length, 3);
    chk("tail_q0", q[0], 8'h31);
    // Tail is kept when eating, so the same head collides.
    build3();
    move(8'h30, 8'h30, 0);
    chk("tail_eat_wr", wr_a[4], 0);
    chk("tail_eat_over", go_a[5], 1);

    // Full snake eating, with a dropped tick during SCAN.
    build3();
    move(8'h33, 8'h33, 0);
    chk("full_length0", length, DEPTH);
    move(8'h34, 8'h34, 1);
    chk("full_c_wr", wr_a[5], 1);
    chk("full_c_rd", rd_a[5], 1);
    chk("full_c_data", dat_a[5], 8'h34);
    chk("full_grow", gr_a[5], 1);
    chk("full_busy_cnt", busy_cnt, 5);
    chk("full_length", length, DEPTH);
    chk("full_score", score, 4);
    repeat (8) @(negedge clk);
    chk("drop_busy", busy, 0);
    chk("drop_score", score, 4);
    chk("drop_qsize", q.size(), DEPTH);

    // Score saturation while full.
    for (int n = 0; n < 252; n++) move(8'h40 + 8'(n % 16), 8'h40 + 8'(n % 16), 0);
    chk("sat_score", score, 255);
    chk("sat_length", length, DEPTH);
    chk("sat_over", game_over, 0);

    chk("fifo_ovf", ovf, 0);
    chk("fifo_udf", udf, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
